uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side buffer that sits directly upstream of the UART transmitter: it accepts parallel words from the host at up to one per clock, stores them in a circular FIFO, and dispatches them one at a time to the transmitter using a single-cycle data-valid pulse gated by the transmitter's Busy flag. It lets the host burst data without polling Busy, and it runs entirely in the transmit clock domain.

## Interface
- DATA_LENGTH, 8, word width; must match the transmitter's DATA_LENGTH.
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16 entries).

- CLK  input  1  transmit clock (same clock as the transmitter).
- RST  input  1  asynchronous, active-low reset.
- WR_DATA  input  DATA_LENGTH  word to enqueue.
- WR_EN  input  1  enqueue request, sampled on the rising edge of CLK.
- FULL  output  1  FIFO holds DEPTH words.
- EMPTY  output  1  FIFO holds 0 words.
- COUNT  output  DEPTH_LOG2+1  number of stored words, 0..DEPTH.
- OVERFLOW  output  1  sticky flag: a write was dropped.
- OVF_CLR  input  1  clears OVERFLOW.
- TX_P_DATA  output  DATA_LENGTH  word presented to the transmitter's parallel data input.
- TX_DATA_VALID  output  1  one-cycle dispatch strobe to the transmitter.
- TX_BUSY  input  1  transmitter Busy flag.

## Operation
- Storage: DEPTH x DATA_LENGTH register array with DEPTH_LOG2-bit read/write pointers that wrap modulo DEPTH, plus a (DEPTH_LOG2+1)-bit COUNT register. FULL = (COUNT == DEPTH). EMPTY = (COUNT == 0). FULL and EMPTY are decoded from the COUNT register, not from the pointers.
- Write: when WR_EN=1 and FULL=0, store WR_DATA at the write pointer and increment the write pointer.
- Write when full: when WR_EN=1 and FULL=1, the word is dropped and the memory and pointers are unchanged. This holds even if a pop occurs in the same cycle.
- Dispatch FSM, 3 states:
  - IDLE: if EMPTY=0 and TX_BUSY=0, pop: load TX_P_DATA from the read pointer, increment the read pointer, pulse TX_DATA_VALID for one cycle, go to WAIT_BUSY. Otherwise stay in IDLE.
  - WAIT_BUSY: stay until TX_BUSY=1, then go to WAIT_DONE. No pop occurs in this state; this guards against the transmitter's one-cycle Busy latency.
  - WAIT_DONE: stay while TX_BUSY=1. On TX_BUSY=0, go to IDLE.
- COUNT update: +1 on an accepted write only, -1 on a pop only, unchanged when both or neither occur in the same cycle.
- Pop and write in the same cycle when COUNT=1: the pop takes the old word, the new word is stored, COUNT stays 1.
- TX_P_DATA is registered. It holds its value from the TX_DATA_VALID cycle until the next pop.

## Timing
- Reset (RST=0, asynchronous) clears:
  - pointers, COUNT = 0, state = IDLE;
  - TX_DATA_VALID = 0, TX_P_DATA = 0, OVERFLOW = 0;
  - FULL = 0, EMPTY = 1.
  - Memory contents are not reset.
- Reset deassertion is used as-is; the RST input is synchronised externally.
- Reset asserted mid-transfer: the FIFO contents are discarded and the FSM returns to IDLE immediately.
- Write latency: a word written at edge N to an empty FIFO, with the FSM in IDLE and TX_BUSY=0, produces TX_DATA_VALID=1 in the cycle after edge N+1. Minimum is 1 cycle from write to strobe.
- Pop rate: at most one pop per transmitter frame. TX_DATA_VALID is never asserted in two consecutive cycles.
- FULL, EMPTY and COUNT reflect the state after each edge, with no combinational path from WR_EN.

## Configuration
- UART_TX_FIFO_OVF_FLAG_EN defined:
  - OVERFLOW sets on any dropped write.
  - OVERFLOW stays set until OVF_CLR=1 is sampled.
  - If a set and OVF_CLR occur in the same cycle, OVERFLOW remains 1.
- Not defined: OVERFLOW is tied to 0 and OVF_CLR is ignored. Both ports remain present, and dropped-write behaviour is unchanged.

## Test plan
- Reset, then write 0xA5 with TX_BUSY=0 -> one TX_DATA_VALID pulse 1 cycle later with TX_P_DATA=0xA5. Afterwards COUNT=0 and EMPTY=1.
- Write 3 words 0x11, 0x22, 0x33 back-to-back. Hold TX_BUSY high for 20 cycles after each strobe, with Busy rising 1 cycle after the strobe -> exactly 3 strobes in order 0x11, 0x22, 0x33, none while TX_BUSY=1.
- Hold TX_BUSY=1 and write 17 words (DEPTH=16) -> FULL=1 after the 16th, the 17th is dropped, COUNT=16. With the macro defined, OVERFLOW=1 until OVF_CLR is asserted.
- Hold the FIFO full and assert WR_EN in the same cycle as a pop -> COUNT=15 and the write is dropped.
- Keep COUNT=1 and write during a pop cycle -> COUNT stays 1, and the next strobe carries the new word.
- Assert RST=0 in WAIT_DONE with COUNT=5 -> TX_DATA_VALID=0, COUNT=0, EMPTY=1 asynchronously. No strobe occurs after release until a new write.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_if
// Bundles the signals of the UART transmit FIFO. It covers the host write
// side, the status flags and the transmitter dispatch side.
//   master : environment side. It is the host that writes words plus the
//            transmitter that reports Busy.
//   slave  : the FIFO itself.
// Signals:
//   wr_data/wr_en   word to enqueue / enqueue request
//   full/empty      FIFO holds DEPTH / 0 words
//   count           number of stored words, 0..DEPTH
//   overflow        sticky dropped-write flag
//   ovf_clr         clears overflow
//   tx_p_data       word presented to the transmitter
//   tx_data_valid   one-cycle dispatch strobe
//   tx_busy         transmitter Busy flag
// ----------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int DATA_LENGTH = 8,
    parameter int DEPTH_LOG2  = 4
) ();
    logic [DATA_LENGTH-1:0] wr_data;
    logic                   wr_en;
    logic                   full;
    logic                   empty;
    logic [DEPTH_LOG2:0]    count;
    logic                   overflow;
    logic                   ovf_clr;
    logic [DATA_LENGTH-1:0] tx_p_data;
    logic                   tx_data_valid;
    logic                   tx_busy;

    modport master (
        output wr_data, wr_en, ovf_clr, tx_busy,
        input  full, empty, count, overflow, tx_p_data, tx_data_valid
    );

    modport slave (
        input  wr_data, wr_en, ovf_clr, tx_busy,
        output full, empty, count, overflow, tx_p_data, tx_data_valid
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// Transmit-side circular FIFO in front of a UART transmitter. The host may
// write one word per clock. Stored words are dispatched one at a time with a
// single-cycle tx_data_valid strobe. The strobe fires only when the
// transmitter is idle, and at most one word goes out per transmitter frame.
//
// Ports:
//   clk    transmit clock (shared with the transmitter)
//   rst_n  asynchronous active-low reset, synchronised externally
//   bus    uart_tx_fifo_if.slave. It carries wr_data, wr_en, ovf_clr and
//          tx_busy in, and full, empty, count, overflow, tx_p_data and
//          tx_data_valid out.
//
// Optional feature:
//   UART_TX_FIFO_OVF_FLAG_EN  when defined, overflow is a sticky flag. It
//   sets on a dropped write and is cleared by ovf_clr, with set taking
//   priority. When undefined, overflow reads 0 and ovf_clr is ignored.
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_LENGTH = 8,
    parameter int DEPTH_LOG2  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_fifo_if.slave    bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    logic [DATA_LENGTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_reg;
    logic [DEPTH_LOG2-1:0]  rd_ptr_reg;
    logic [DEPTH_LOG2:0]    count_reg;
    state_t                 state_reg;
    logic                   tx_data_valid_reg;
    logic [DATA_LENGTH-1:0] tx_p_data_reg;

    logic full_int;
    logic empty_int;
    logic wr_accept;
    logic pop;

    // Flags come from the count register, so wr_en has no combinational
    // path to them.
    assign full_int  = (count_reg == CNT_FULL);
    assign empty_int = (count_reg == '0);

    // A write to a full FIFO is dropped even if a pop frees a slot in the
    // same cycle.
    assign wr_accept = bus.wr_en & ~full_int;
    assign pop       = (state_reg == IDLE) & ~empty_int & ~bus.tx_busy;

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
        end else if (wr_accept) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        end
    end

    // A write and a pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            case ({wr_accept, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Dispatch FSM. WAIT_BUSY absorbs the transmitter's one-cycle Busy
    // latency, so a second word cannot be popped before Busy has risen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            rd_ptr_reg        <= '0;
            tx_data_valid_reg <= 1'b0;
            tx_p_data_reg     <= '0;
        end else begin
            tx_data_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        tx_p_data_reg     <= mem[rd_ptr_reg];
                        rd_ptr_reg        <= rd_ptr_reg + PTR_ONE;
                        tx_data_valid_reg <= 1'b1;
                        state_reg         <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_FLAG_EN
    logic overflow_reg;

    // Set wins over clear when both happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (bus.wr_en && full_int) begin
            overflow_reg <= 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_reg <= 1'b0;
        end
    end

    assign bus.overflow = overflow_reg;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = bus.ovf_clr;
    assign bus.overflow   = 1'b0;
`endif

    assign bus.full          = full_int;
    assign bus.empty         = empty_int;
    assign bus.count         = count_reg;
    assign bus.tx_p_data     = tx_p_data_reg;
    assign bus.tx_data_valid = tx_data_valid_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo (DATA_LENGTH=8, DEPTH_LOG2=4). Inputs
// change on the falling edge and outputs are observed there. A small
// transmitter model runs inside the cycle task. After each strobe it raises
// Busy one cycle later and holds it for 20 cycles. Every dispatched word is
// logged so that ordering and dropped writes can be checked.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo;
    logic clk;
    logic rst_n;

    uart_tx_fifo_if #(.DATA_LENGTH(8), .DEPTH_LOG2(4)) bus_if ();

    uart_tx_fifo #(.DATA_LENGTH(8), .DEPTH_LOG2(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

`ifdef UART_TX_FIFO_OVF_FLAG_EN
    logic ovf_exp = 1'b1;
`else
    logic ovf_exp = 1'b0;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    int         busy_left = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] got [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then observe at the falling edge and run the
    // transmitter model.
    task automatic cyc();
        @(negedge clk);
        if (bus_if.tx_data_valid === 1'b1) begin
            chk("strobe_while_busy", 32'(bus_if.tx_busy), 32'd0);
            chk("strobe_back_to_back", 32'(prev_valid), 32'd0);
            got.push_back(bus_if.tx_p_data);
            $display("strobe: tx_p_data=0x%02h count=%0d", bus_if.tx_p_data, bus_if.count);
            bus_if.tx_busy = 1'b1;
            busy_left = 20;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) bus_if.tx_busy = 1'b0;
        end
        prev_valid = bus_if.tx_data_valid;
    endtask

    task automatic write_word(input logic [7:0] d);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_data = d;
        cyc();
        bus_if.wr_en   = 1'b0;
        $display("write: data=0x%02h count=%0d full=%0b", d, bus_if.count, bus_if.full);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_data = 8'h00;
        bus_if.ovf_clr = 1'b0;
        bus_if.tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_count", 32'(bus_if.count), 32'd0);
        chk("rst_empty", 32'(bus_if.empty), 32'd1);
        chk("rst_full", 32'(bus_if.full), 32'd0);
        chk("rst_valid", 32'(bus_if.tx_data_valid), 32'd0);
        chk("rst_pdata", 32'(bus_if.tx_p_data), 32'd0);
        chk("rst_ovf", 32'(bus_if.overflow), 32'd0);

        // Single word: strobe one cycle after the write edge
        write_word(8'hA5);
        chk("t1_count_after_wr", 32'(bus_if.count), 32'd1);
        chk("t1_no_early_strobe", 32'(bus_if.tx_data_valid), 32'd0);
        cyc();
        chk("t1_valid", 32'(bus_if.tx_data_valid), 32'd1);
        chk("t1_pdata", 32'(bus_if.tx_p_data), 32'hA5);
        chk("t1_count", 32'(bus_if.count), 32'd0);
        chk("t1_empty", 32'(bus_if.empty), 32'd1);
        cyc();
        chk("t1_single_pulse", 32'(bus_if.tx_data_valid), 32'd0);
        chk("t1_pdata_hold", 32'(bus_if.tx_p_data), 32'hA5);
        repeat (30) cyc();
        chk("t1_strobes", 32'(got.size()), 32'd1);

        // Three words back-to-back, paced by Busy
        got.delete();
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        repeat (100) cyc();
        chk("t2_strobes", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("t2_word0", 32'(got[0]), 32'h11);
            chk("t2_word1", 32'(got[1]), 32'h22);
            chk("t2_word2", 32'(got[2]), 32'h33);
        end
        chk("t2_empty", 32'(bus_if.empty), 32'd1);

        // Fill while Busy is held: 17 writes, the last one dropped
        got.delete();
        bus_if.tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            write_word(8'(8'h40 + i));
            if (i == 15) begin
                chk("t3_full_at16", 32'(bus_if.full), 32'd1);
                chk("t3_ovf_before_drop", 32'(bus_if.overflow), 32'd0);
            end
        end
        chk("t3_count", 32'(bus_if.count), 32'd16);
        chk("t3_full", 32'(bus_if.full), 32'd1);
        chk("t3_not_empty", 32'(bus_if.empty), 32'd0);
        chk("t3_ovf_set", 32'(bus_if.overflow), 32'(ovf_exp));
        cyc();
        chk("t3_ovf_sticky", 32'(bus_if.overflow), 32'(ovf_exp));
        bus_if.wr_en   = 1'b1;
        bus_if.wr_data = 8'hEE;
        bus_if.ovf_clr = 1'b1;
        cyc();
        bus_if.wr_en = 1'b0;
        chk("t3_ovf_set_beats_clr", 32'(bus_if.overflow), 32'(ovf_exp));
        cyc();
        bus_if.ovf_clr = 1'b0;
        chk("t3_ovf_cleared", 32'(bus_if.overflow), 32'd0);
        chk("t3_no_strobe", 32'(got.size()), 32'd0);

        // Write into a full FIFO in the pop cycle: write is dropped
        bus_if.tx_busy = 1'b0;
        busy_left      = 0;
        bus_if.wr_en   = 1'b1;
        bus_if.wr_data = 8'hEE;
        cyc();
        bus_if.wr_en = 1'b0;
        chk("t4_count", 32'(bus_if.count), 32'd15);
        chk("t4_full", 32'(bus_if.full), 32'd0);
        chk("t4_pdata", 32'(bus_if.tx_p_data), 32'h40);
        repeat (400) cyc();
        chk("t4_strobes", 32'(got.size()), 32'd16);
        if (got.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("t4_word%0d", i), 32'(got[i]), 32'(8'h40 + i));
            end
        end
        chk("t4_empty", 32'(bus_if.empty), 32'd1);

        // COUNT=1 with a write in the pop cycle
        got.delete();
        bus_if.tx_busy = 1'b1;
        write_word(8'h77);
        chk("t5_count_pre", 32'(bus_if.count), 32'd1);
        bus_if.tx_busy = 1'b0;
        write_word(8'h88);
        chk("t5_count_hold", 32'(bus_if.count), 32'd1);
        chk("t5_first_strobe", 32'(got.size()), 32'd1);
        repeat (60) cyc();
        chk("t5_strobes", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("t5_word0", 32'(got[0]), 32'h77);
            chk("t5_word1", 32'(got[1]), 32'h88);
        end
        chk("t5_empty", 32'(bus_if.empty), 32'd1);

        // Reset asserted in WAIT_DONE with COUNT=5
        got.delete();
        bus_if.tx_busy = 1'b1;
        for (int i = 0; i < 6; i++) write_word(8'(8'h91 + i));
        chk("t6_count6", 32'(bus_if.count), 32'd6);
        bus_if.tx_busy = 1'b0;
        cyc();
        chk("t6_count5", 32'(bus_if.count), 32'd5);
        repeat (3) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus_if.tx_data_valid), 32'd0);
        chk("t6_rst_count", 32'(bus_if.count), 32'd0);
        chk("t6_rst_empty", 32'(bus_if.empty), 32'd1);
        chk("t6_rst_pdata", 32'(bus_if.tx_p_data), 32'd0);
        $display("reset: asserted mid-transfer count=%0d", bus_if.count);
        @(negedge clk);
        rst_n          = 1'b1;
        bus_if.tx_busy = 1'b0;
        busy_left      = 0;
        prev_valid     = 1'b0;
        repeat (30) cyc();
        chk("t6_no_strobe_after_rst", 32'(got.size()), 32'd1);
        chk("t6_still_empty", 32'(bus_if.empty), 32'd1);
        write_word(8'hC3);
        cyc();
        chk("t6_new_strobe", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("t6_new_word", 32'(got[1]), 32'hC3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
